st_stream_sink: RTL and testbench

ST_STREAM_SINK -- requirements
Module: st_stream_sink

---
 rtl/st_stream_sink.sv | 106 ++++++++++
 tb/tb_st_stream_sink.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/st_stream_sink.sv
// Byte-stream sink: a DEPTH-entry FIFO fed by an upstream that cannot be stalled.
// Also tracks overflow, completed bursts and a running checksum of accepted bytes.
module st_stream_sink #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DATA_W-1:0]      data,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   in_burst,
    output logic [15:0]            burst_cnt,
    output logic [DATA_W-1:0]      checksum,
    input  logic                   clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_ptr_inc;
    logic [DATA_W-1:0] head_nxt;
    logic              full, pop, push, drop, burst_end;

    assign full       = (level == LW'(DEPTH));
    assign out_valid  = (level != '0);
    assign pop        = out_valid && out_ready;
    assign push       = enable && (!full || pop);
    assign drop       = enable && !push;
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign in_burst   = (state == BURST);

    // out_data is a register holding the head entry; on an empty FIFO the
    // incoming byte bypasses storage so it is visible right after its edge.
    always_comb begin
        head_nxt = out_data;
        if (pop) begin
            if (level > LW'(1))
                head_nxt = mem[rd_ptr_inc];
            else if (push)
                head_nxt = data;
        end else if (!out_valid && push) begin
            head_nxt = data;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_end = 1'b0;
        case (state)
            IDLE:  if (enable) state_nxt = BURST;
            BURST: if (!enable) begin
                state_nxt = IDLE;
                burst_end = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_data  <= '0;
            state     <= IDLE;
            overflow  <= 1'b0;
            burst_cnt <= '0;
            checksum  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            out_data <= head_nxt;
            state    <= state_nxt;
            // clear wins, but a byte accepted in the clear cycle still seeds the checksum
            if (clear) begin
                overflow  <= 1'b0;
                burst_cnt <= '0;
                checksum  <= push ? data : '0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (burst_end && burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
                if (push) checksum <= checksum + data;
            end
        end
    end

endmodule

// File: tb/tb_st_stream_sink.sv
// Randomized and directed bench for st_stream_sink: a queue-based reference model
// feeds a scoreboard that a negedge monitor drains against the DUT outputs.
module tb_st_stream_sink;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              in_burst;
    logic [15:0]       burst_cnt;
    logic [DATA_W-1:0] checksum;
    logic              clear = 1'b0;

    st_stream_sink #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data(data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .overflow(overflow), .in_burst(in_burst),
        .burst_cnt(burst_cnt), .checksum(checksum), .clear(clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DATA_W-1:0] m_q[$];     // model FIFO contents
    logic [DATA_W-1:0] exp_q[$];   // scoreboard of bytes expected on out_data
    bit                m_ovf;
    bit                m_inb;
    int                m_bcnt;
    logic [DATA_W-1:0] m_sum;

    function automatic void chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        exp_q.delete();
        m_ovf  = 0;
        m_inb  = 0;
        m_bcnt = 0;
        m_sum  = '0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            bit do_pop, do_push, ended;
            do_pop  = (m_q.size() > 0) && out_ready;
            do_push = enable && (m_q.size() < DEPTH || do_pop);
            ended   = m_inb && !enable;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(data);
                exp_q.push_back(data);
            end
            m_inb = enable;
            if (clear) begin
                m_ovf  = 0;
                m_bcnt = 0;
                m_sum  = do_push ? data : '0;
            end else begin
                if (enable && !do_push) m_ovf = 1;
                if (ended && m_bcnt < 65535) m_bcnt++;
                if (do_push) m_sum = m_sum + data;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", out_valid, m_q.size() != 0);
            chk("level", level, m_q.size());
            chk("overflow", overflow, m_ovf);
            chk("in_burst", in_burst, m_inb);
            chk("burst_cnt", burst_cnt, m_bcnt);
            chk("checksum", checksum, m_sum);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // apply inputs for one edge; returns 1 time unit after that edge
    task automatic step(input bit en, input logic [DATA_W-1:0] d, input bit rdy, input bit clr);
        enable = en; data = d; out_ready = rdy; clear = clr;
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_inb"}, in_burst, 0);
        chk({tag, "_bcnt"}, burst_cnt, 0);
        chk({tag, "_sum"}, checksum, 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk_zero("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // single byte
        step(1, 8'hA5, 1, 0);
        chk("single_data", out_data, 8'hA5);
        chk("single_sum", checksum, 8'hA5);
        step(0, 0, 1, 0);
        chk("single_bcnt", burst_cnt, 1);
        step(0, 0, 1, 1);

        // fill past full
        for (int i = 0; i < 10; i++) step(1, DATA_W'(i), 0, 0);
        step(0, 0, 0, 0);
        chk("fill_level", level, 8);
        chk("fill_ovf", overflow, 1);
        chk("fill_sum", checksum, 8'h1C);
        chk("fill_head", out_data, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // full with concurrent pop across pointer wrap
        for (int i = 0; i < 8; i++) step(1, DATA_W'(8'h10 + i), 0, 0);
        for (int i = 0; i < 4; i++) step(1, DATA_W'(8'h20 + i), 1, 0);
        chk("fullpop_level", level, 8);
        chk("fullpop_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

        // checksum wrap
        step(0, 0, 0, 1);
        step(1, 8'hFF, 1, 0);
        step(1, 8'h02, 1, 0);
        step(0, 0, 1, 0);
        chk("wrap_sum", checksum, 8'h01);

        // clear coincident with push after overflow and bursts
        for (int i = 0; i < 9; i++) step(1, DATA_W'(8'h40 + i), 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        chk("pre_clr_level", level, 3);
        step(1, 8'h33, 0, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_bcnt", burst_cnt, 0);
        chk("clr_sum", checksum, 8'h33);
        chk("clr_level", level, 4);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // async reset mid-burst with five entries
        for (int i = 0; i < 5; i++) step(1, DATA_W'(8'h60 + i), 0, 0);
        chk("prerst_level", level, 5);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_zero("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, 8'h5A, 0, 0);
        chk("post_rst_head", out_data, 8'h5A);
        chk("post_rst_level", level, 1);
        step(0, 0, 1, 0);
        chk("post_rst_bcnt", burst_cnt, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6, DATA_W'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 3);
        end
        step(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
